// File: rtl/stat_cdc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : stat_cdc_pkg
// Purpose  : Default sizing and per-channel status record for stat_cdc_rx.
// Revision : 1.0
// ============================================================================
package stat_cdc_pkg;

    localparam int c_n_channels = 16;
    localparam int c_width      = 64;
    localparam int c_n_stage    = 3;
    localparam int c_cnt_width  = 32;

    // Register-file view of one channel at default sizing.
    typedef struct packed {
        logic [c_width-1:0]     data;
        logic [c_cnt_width-1:0] count;
        logic                   fresh;
    } chan_status_t;

endpackage
`default_nettype wire

// File: rtl/sync_flops.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_flops
// Purpose  : N_STAGE-deep async-reset single-bit synchroniser.
// Revision : 1.0
// ============================================================================
module sync_flops #(
    parameter int N_STAGE = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [N_STAGE-1:0] r_sync;

    if (N_STAGE < 2 || N_STAGE > 6) begin : g_bad_stage
        $error("sync_flops: N_STAGE must be in 2..6");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[N_STAGE-2:0], i_d};
        end
    end

    assign o_q = r_sync[N_STAGE-1];

endmodule
`default_nettype wire

// File: rtl/stat_cdc_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : stat_cdc_rx
// Purpose  : Receiving half of a toggle req/ack CDC handshake collecting
//            per-channel status words into the AXI-lite clock domain.
// Revision : 1.0
// ============================================================================
module stat_cdc_rx
    import stat_cdc_pkg::*;
#(
    parameter int N_CHANNELS = c_n_channels,
    parameter int WIDTH      = c_width,
    parameter int N_STAGE    = c_n_stage,
    parameter int CNT_WIDTH  = c_cnt_width
) (
    input  logic                  s_axil_aclk,
    input  logic                  s_axil_rst,
    input  logic [N_CHANNELS-1:0] req_tgl,
    input  logic [WIDTH-1:0]      din [N_CHANNELS],
    output logic [N_CHANNELS-1:0] ack_tgl,
    input  logic                  freeze,
    input  logic [N_CHANNELS-1:0] rd_clr,
    output logic [WIDTH-1:0]      dout [N_CHANNELS],
    output logic [N_CHANNELS-1:0] dout_upd,
    output logic [N_CHANNELS-1:0] fresh,
    output logic [CNT_WIDTH-1:0]  cap_cnt [N_CHANNELS],
    output logic                  any_pending
);

    logic [N_CHANNELS-1:0] w_req_s;
    logic [N_CHANNELS-1:0] w_pending;
    logic                  r_any_pending;

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
        logic                 w_capture;
        logic                 r_req_seen;
        logic                 r_upd;
        logic                 r_fresh;
        logic [WIDTH-1:0]     r_dout;
        logic [CNT_WIDTH-1:0] r_cnt;

        sync_flops #(
            .N_STAGE (N_STAGE)
        ) u_req_sync (
            .clk (s_axil_aclk),
            .rst (s_axil_rst),
            .i_d (req_tgl[i]),
            .o_q (w_req_s[i])
        );

        assign w_pending[i] = w_req_s[i] ^ r_req_seen;
        // Frozen requests stay pending and commit on the first unfrozen edge.
        assign w_capture    = w_pending[i] & ~freeze;

        always_ff @(posedge s_axil_aclk or posedge s_axil_rst) begin
            if (s_axil_rst) begin
                r_req_seen <= 1'b0;
                r_upd      <= 1'b0;
                r_fresh    <= 1'b0;
                r_dout     <= '0;
                r_cnt      <= '0;
            end else begin
                r_upd <= w_capture;
                if (w_capture) begin
                    r_req_seen <= w_req_s[i];
                    r_dout     <= din[i];
                    r_cnt      <= r_cnt + 1'b1;
                    r_fresh    <= 1'b1;
                end else if (rd_clr[i]) begin
                    r_fresh    <= 1'b0;
                end
            end
        end

        assign ack_tgl[i]  = r_req_seen;
        assign dout_upd[i] = r_upd;
        assign fresh[i]    = r_fresh;
        assign dout[i]     = r_dout;
        assign cap_cnt[i]  = r_cnt;
    end

    always_ff @(posedge s_axil_aclk or posedge s_axil_rst) begin
        if (s_axil_rst) begin
            r_any_pending <= 1'b0;
        end else begin
            r_any_pending <= |w_pending;
        end
    end

    assign any_pending = r_any_pending;

endmodule
`default_nettype wire
